// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard/forwarding control: forwarding
// select encodings, hazard FSM states and the hardwired-zero register index.
package pipeline_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  localparam int unsigned ZERO_REG    = 0;
  localparam int unsigned FLUSH_CNT_W = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hcu_state_t;

endpackage

// File: rtl/operand_forward_sel.sv
// Per-operand dependency check against the EX and MEM producers; yields the
// forwarding select for the instruction about to enter EX (youngest wins).
module operand_forward_sel
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  ex_match,
  output logic [1:0]            sel
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  logic live;
  logic mem_match;

  // r0 reads are constant, so they never depend on an in-flight producer
  assign live      = id_valid & src_used & (src != ZERO_IDX);
  assign ex_match  = live & ex_reg_write  & (src == ex_rd);
  assign mem_match = live & mem_reg_write & (src == mem_rd);

  always_comb begin
    sel = FWD_REGFILE;
    if (ex_match) begin
      sel = FWD_EXMEM;
    end else if (mem_match) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush FSM,
// registered EX forwarding selects and saturating stall/flush counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_READ     = 2,
  parameter int BRANCH_FLUSH = 1,
  parameter int PERF_W       = 16
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           idValid,
  input  logic [NUM_READ*REG_ADDR_W-1:0] idSrc,
  input  logic [NUM_READ-1:0]            idSrcUsed,
  input  logic                           exRegWrite,
  input  logic                           exMemRead,
  input  logic [REG_ADDR_W-1:0]          exRd,
  input  logic                           memRegWrite,
  input  logic [REG_ADDR_W-1:0]          memRd,
  input  logic                           branchTaken,
  output logic                           pcWrite,
  output logic                           ifIdWrite,
  output logic                           ifIdFlush,
  output logic                           idExBubble,
  output logic [2*NUM_READ-1:0]          fwdSel,
  output logic [PERF_W-1:0]              stallCount,
  output logic [PERF_W-1:0]              flushCount
);

  if (BRANCH_FLUSH < 1 || BRANCH_FLUSH > 7) begin : g_bad_flush_len
    $error("hazard_control_unit: BRANCH_FLUSH must be in 1..7");
  end

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(BRANCH_FLUSH - 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE    = FLUSH_CNT_W'(1);
  // A single-cycle flush is fully handled in the cycle the branch resolves
  localparam hcu_state_t RELOAD_STATE = (BRANCH_FLUSH > 1) ? ST_FLUSH : ST_RUN;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt,
                                                 input logic              en);
    if (en && (cnt != {PERF_W{1'b1}})) begin
      return cnt + PERF_W'(1);
    end
    return cnt;
  endfunction

  hcu_state_t                 state, state_next;
  logic [FLUSH_CNT_W-1:0]     flush_cnt, flush_cnt_next;
  logic [NUM_READ-1:0]        ex_hit;
  logic [2*NUM_READ-1:0]      sel_p0;
  logic [2*NUM_READ-1:0]      fwd_sel_p1;
  logic                       load_use;
  logic                       stall_now;
  logic                       flush_now;

  // ---- ID stage: per-operand dependency resolution ----
  for (genvar k = 0; k < NUM_READ; k++) begin : g_opnd
    operand_forward_sel #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_sel (
      .id_valid     (idValid),
      .src_used     (idSrcUsed[k]),
      .src          (idSrc[k*REG_ADDR_W +: REG_ADDR_W]),
      .ex_reg_write (exRegWrite),
      .ex_rd        (exRd),
      .mem_reg_write(memRegWrite),
      .mem_rd       (memRd),
      .ex_match     (ex_hit[k]),
      .sel          (sel_p0[2*k +: 2])
    );
  end

  assign load_use = exMemRead & (|ex_hit);

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    flush_now      = 1'b0;
    stall_now      = 1'b0;
    case (state)
      ST_RUN: begin
        if (branchTaken) begin
          flush_now      = 1'b1;
          flush_cnt_next = FLUSH_RELOAD;
          state_next     = RELOAD_STATE;
        end else if (load_use) begin
          stall_now = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_now = 1'b1;
        if (branchTaken) begin
          flush_cnt_next = FLUSH_RELOAD;
          state_next     = RELOAD_STATE;
        end else begin
          flush_cnt_next = (flush_cnt != '0) ? flush_cnt - FLUSH_ONE : '0;
          state_next     = (flush_cnt > FLUSH_ONE) ? ST_FLUSH : ST_RUN;
        end
      end
      default: begin
        state_next     = ST_RUN;
        flush_cnt_next = '0;
      end
    endcase
  end

  // Outputs are forced to their idle values while reset is held
  assign pcWrite    = ~(resetN & stall_now);
  assign ifIdWrite  = ~(resetN & stall_now);
  assign ifIdFlush  = resetN & flush_now;
  assign idExBubble = resetN & (flush_now | stall_now);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // ---- ID/EX boundary: forwarding selects for the instruction entering EX ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fwd_sel_p1 <= '0;
    end else if (ifIdWrite || idExBubble) begin
      fwd_sel_p1 <= idExBubble ? '0 : sel_p0;
    end
  end

  assign fwdSel = fwd_sel_p1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      stallCount <= sat_inc(stallCount, stall_now);
      flushCount <= sat_inc(flushCount, flush_now);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table, corner
// sequences (flush, reset mid-flush, saturation) and a randomized model check.
module tb_hazard_control_unit;

  localparam int RW  = 5;
  localparam int NR  = 2;
  localparam int BF  = 3;
  localparam int PW  = 4;
  localparam int CNT_MAX = (1 << PW) - 1;

  logic             clk = 1'b0;
  logic             resetN;
  logic             idValid;
  logic [NR*RW-1:0] idSrc;
  logic [NR-1:0]    idSrcUsed;
  logic             exRegWrite, exMemRead;
  logic [RW-1:0]    exRd;
  logic             memRegWrite;
  logic [RW-1:0]    memRd;
  logic             branchTaken;
  logic             pcWrite, ifIdWrite, ifIdFlush, idExBubble;
  logic [2*NR-1:0]  fwdSel;
  logic [PW-1:0]    stallCount, flushCount;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .REG_ADDR_W(RW), .NUM_READ(NR), .BRANCH_FLUSH(BF), .PERF_W(PW)
  ) dut (
    .clk(clk), .resetN(resetN), .idValid(idValid), .idSrc(idSrc),
    .idSrcUsed(idSrcUsed), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exRd(exRd), .memRegWrite(memRegWrite), .memRd(memRd),
    .branchTaken(branchTaken), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .ifIdFlush(ifIdFlush), .idExBubble(idExBubble), .fwdSel(fwdSel),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  typedef struct {
    logic       idv;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic       exrw, exmr;
    logic [4:0] exrd;
    logic       memrw;
    logic [4:0] memrd;
    logic       br;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [3:0] ctl;   // {pcWrite, ifIdWrite, ifIdFlush, idExBubble}
    logic [3:0] fwd;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic stim_t mk(int idv, int s0, int s1, int used, int exrw, int exmr,
                               int exrd, int memrw, int memrd, int br);
    stim_t s;
    s.idv = 1'(idv);    s.s0 = 5'(s0);       s.s1 = 5'(s1);     s.used = 2'(used);
    s.exrw = 1'(exrw);  s.exmr = 1'(exmr);   s.exrd = 5'(exrd);
    s.memrw = 1'(memrw); s.memrd = 5'(memrd); s.br = 1'(br);
    return s;
  endfunction

  function automatic vec_t mv(stim_t s, logic [3:0] ctl, logic [3:0] fwd);
    vec_t v;
    v.s = s; v.ctl = ctl; v.fwd = fwd;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    idValid = s.idv;  idSrc = {s.s1, s.s0};  idSrcUsed = s.used;
    exRegWrite = s.exrw;  exMemRead = s.exmr;  exRd = s.exrd;
    memRegWrite = s.memrw;  memRd = s.memrd;  branchTaken = s.br;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [3:0] ctl_now();
    return {pcWrite, ifIdWrite, ifIdFlush, idExBubble};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // Reference model: dependency match exactly as the hazard rules state it
  function automatic logic m_match(stim_t s, int k, logic [4:0] rd, logic rw);
    logic [4:0] src;
    src = (k == 0) ? s.s0 : s.s1;
    return s.used[k] && s.idv && (src != 5'd0) && (src == rd) && rw;
  endfunction

  function automatic logic [1:0] m_sel(stim_t s, int k);
    if (m_match(s, k, s.exrd, s.exrw))   return 2'b01;
    if (m_match(s, k, s.memrd, s.memrw)) return 2'b10;
    return 2'b00;
  endfunction

  vec_t  vt[$];
  stim_t q, lu5;
  int    flush_left, m_stall, m_flush, nflush, nstall;
  logic  m_lu, m_fl, m_bub;
  logic [3:0] m_fwd;

  initial begin
    resetN = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5 = mk(1, 0, 5, 2, 1, 1, 5, 0, 0, 0);

    // Reset state, with branch and load-use inputs active
    @(negedge clk);
    drive(mk(1, 5, 5, 3, 1, 1, 5, 1, 5, 1));
    #1;
    chk("reset_ctl", ctl_now(), 4'b1100);
    @(posedge clk); #1;
    chk("reset_fwd", fwdSel, 0);
    chk("reset_stallcnt", stallCount, 0);
    chk("reset_flushcnt", flushCount, 0);
    @(negedge clk);
    resetN = 1'b1;
    drive(q);

    // Directed table, all in RUN
    vt.push_back(mv(mk(1, 3, 0, 1, 1, 0, 3, 0, 0, 0), 4'b1100, 4'b0001));
    vt.push_back(mv(mk(1, 7, 0, 1, 1, 0, 4, 1, 7, 0), 4'b1100, 4'b0010));
    vt.push_back(mv(mk(1, 7, 0, 1, 1, 0, 7, 1, 7, 0), 4'b1100, 4'b0001));
    vt.push_back(mv(mk(1, 0, 5, 2, 1, 1, 5, 0, 0, 0), 4'b0001, 4'b0000));
    vt.push_back(mv(mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0), 4'b1100, 4'b0000));
    vt.push_back(mv(mk(1, 5, 5, 0, 1, 1, 5, 1, 5, 0), 4'b1100, 4'b0000));
    vt.push_back(mv(mk(0, 3, 3, 3, 1, 1, 3, 1, 3, 0), 4'b1100, 4'b0000));
    vt.push_back(mv(mk(1, 7, 3, 3, 1, 0, 3, 1, 7, 0), 4'b1100, 4'b0110));
    vt.push_back(mv(mk(1, 9, 0, 1, 0, 0, 9, 0, 0, 0), 4'b1100, 4'b0000));
    vt.push_back(mv(mk(1, 6, 6, 3, 0, 0, 2, 1, 6, 0), 4'b1100, 4'b1010));
    vt.push_back(mv(mk(1, 4, 0, 1, 0, 1, 4, 1, 4, 0), 4'b1100, 4'b0010));
    vt.push_back(mv(mk(1, 2, 8, 3, 1, 1, 8, 1, 2, 0), 4'b0001, 4'b0000));
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].s);
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl_now(), vt[i].ctl);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_fwd", i), fwdSel, vt[i].fwd);
    end

    // Load-use: one stall, then MEM forwarding on the retried operand
    do_reset();
    @(negedge clk); drive(lu5); #1;
    chk("lu_stall_ctl", ctl_now(), 4'b0001);
    @(posedge clk); #1;
    chk("lu_stallcnt", stallCount, 1);
    chk("lu_bubble_fwd", fwdSel, 0);
    @(negedge clk); drive(mk(1, 0, 5, 2, 0, 0, 0, 1, 5, 0)); #1;
    chk("lu_retry_ctl", ctl_now(), 4'b1100);
    @(posedge clk); #1;
    chk("lu_retry_fwd_op1", fwdSel[3:2], 2'b10);
    chk("lu_retry_stallcnt", stallCount, 1);

    // Branch flush of BF cycles with a simultaneous load-use
    do_reset();
    nflush = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 3) begin
        stim_t s;
        s = lu5;
        s.br = (i == 0);
        drive(s);
      end else begin
        drive(q);
      end
      #1;
      if (ifIdFlush) nflush++;
      chk($sformatf("flush_cyc%0d_ctl", i), ctl_now(), (i < 3) ? 4'b1111 : 4'b1100);
      @(posedge clk);
    end
    #1;
    chk("flush_cycles", nflush, BF);
    chk("flush_flushcnt", flushCount, BF);
    chk("flush_stallcnt", stallCount, 0);

    // Reset asserted during the second flush cycle
    do_reset();
    @(negedge clk); drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); #1;
    @(posedge clk);
    @(negedge clk); drive(q); #1;
    chk("midflush_before_rst", ifIdFlush, 1);
    resetN = 1'b0; #1;
    chk("midflush_rst_ctl", ctl_now(), 4'b1100);
    chk("midflush_rst_flushcnt", flushCount, 0);
    chk("midflush_rst_stallcnt", stallCount, 0);
    @(negedge clk); resetN = 1'b1;
    @(negedge clk); drive(q); #1;
    chk("midflush_after_rst_run", ctl_now(), 4'b1100);

    // Saturation of both counters
    do_reset();
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(lu5); #1;
      if (!pcWrite) nstall++;
      @(posedge clk);
    end
    #1;
    chk("sat_stall_cycles", nstall, 20);
    chk("sat_stallcnt", stallCount, CNT_MAX);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk);
    end
    #1;
    chk("sat_flushcnt", flushCount, CNT_MAX);
    chk("sat_stallcnt_hold", stallCount, CNT_MAX);

    // Randomized run against the reference model
    do_reset();
    flush_left = 0; m_stall = 0; m_flush = 0; m_fwd = 4'b0;
    for (int c = 0; c < 1500; c++) begin
      stim_t s;
      s = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0));
      @(negedge clk); drive(s); #1;
      m_lu = 1'b0;
      if (s.br) begin
        m_fl = 1'b1;
        flush_left = BF - 1;
      end else if (flush_left > 0) begin
        m_fl = 1'b1;
        flush_left--;
      end else begin
        m_fl = 1'b0;
        m_lu = s.exmr && (m_match(s, 0, s.exrd, s.exrw) || m_match(s, 1, s.exrd, s.exrw));
      end
      m_bub = m_fl || m_lu;
      chk($sformatf("rand%0d_ctl", c), ctl_now(), {!m_lu, !m_lu, m_fl, m_bub});
      m_fwd   = m_bub ? 4'b0 : {m_sel(s, 1), m_sel(s, 0)};
      m_stall = (m_lu && m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      m_flush = (m_fl && m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      @(posedge clk); #1;
      chk($sformatf("rand%0d_fwd", c), fwdSel, m_fwd);
      chk($sformatf("rand%0d_cnt", c), {stallCount, flushCount}, {4'(m_stall), 4'(m_flush)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
